// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the memory-side responder: loader FSM states,
// I/O page register offsets and timer control bit positions.
package mem_responder_pkg;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [7:0] OFS_GPIO_OUT = 8'h00;
  localparam logic [7:0] OFS_GPIO_IN  = 8'h01;
  localparam logic [7:0] OFS_TMR_LO   = 8'h02;
  localparam logic [7:0] OFS_TMR_HI   = 8'h03;
  localparam logic [7:0] OFS_TMR_CTL  = 8'h04;

  localparam int CTL_EN_BIT  = 0;
  localparam int CTL_CLR_BIT = 1;

  localparam logic [15:0] MMIO_BASE_DEFAULT = 16'hFF00;
  localparam logic [7:0]  UNMAPPED_DATA     = 8'h00;

endpackage

// File: rtl/mem_responder_timer.sv
// Free-running 16-bit timer with enable, write-1 clear and a high-byte shadow
// latched on low-byte reads so the CPU sees a coherent 16-bit value.
module mmio_timer
  import mem_responder_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ctl_we,
  input  logic       ctl_en,
  input  logic       ctl_clr,
  input  logic       lo_rd,
  output logic [7:0] count_lo,
  output logic       enable,
  output logic [7:0] shadow
);

  logic [15:0] count;

  assign count_lo = count[7:0];

  // A clear written together with an increment wins, so the count is 0 next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      enable <= 1'b0;
      shadow <= '0;
    end else begin
      if (ctl_we) begin
        enable <= ctl_en;
      end
      if (ctl_we && ctl_clr) begin
        count <= '0;
      end else if (enable) begin
        count <= count + 16'd1;
      end
      if (lo_rd) begin
        shadow <= count[15:8];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: RAM, GPIO and timer I/O page behind a single-cycle CPU
// port, plus a boot loader that fills RAM while holding the CPU in reset.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int          ADDR_WIDTH = 8,
  parameter logic [15:0] MMIO_BASE  = MMIO_BASE_DEFAULT,
  parameter bit          LOAD_EN    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mem_rw,
  input  logic [15:0] mem_addr,
  input  logic [7:0] mem_data,
  output logic [7:0] mem_q,
  output logic       cpu_rst,
  input  logic       load_valid,
  input  logic [7:0] load_data,
  input  logic       load_last,
  output logic       load_ready,
  output logic       load_done,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = {ADDR_WIDTH{1'b1}};

  state_t                state;
  logic [ADDR_WIDTH-1:0] load_ptr;
  logic [7:0]            ram [RAM_DEPTH];
  logic [7:0]            gpio_sync1;
  logic [7:0]            gpio_sync2;

  logic                  hit_ram;
  logic                  hit_io;
  logic [7:0]            io_ofs;
  logic [ADDR_WIDTH-1:0] ram_index;
  logic                  cpu_wr;
  logic                  cpu_rd;
  logic [7:0]            rd_data;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_waddr;
  logic [7:0]            ram_wdata;

  logic                  tmr_ctl_we;
  logic                  tmr_lo_rd;
  logic [7:0]            tmr_count_lo;
  logic                  tmr_enable;
  logic [7:0]            tmr_shadow;

  assign hit_ram   = ((mem_addr >> ADDR_WIDTH) == 16'd0);
  assign hit_io    = !hit_ram && (mem_addr[15:8] == MMIO_BASE[15:8]);
  assign io_ofs    = mem_addr[7:0];
  assign ram_index = mem_addr[ADDR_WIDTH-1:0];
  assign cpu_wr    = (state == ST_RUN) && mem_rw;
  assign cpu_rd    = (state == ST_RUN) && !mem_rw;

  assign tmr_ctl_we = cpu_wr && hit_io && (io_ofs == OFS_TMR_CTL);
  assign tmr_lo_rd  = cpu_rd && hit_io && (io_ofs == OFS_TMR_LO);

  mmio_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .ctl_we   (tmr_ctl_we),
    .ctl_en   (mem_data[CTL_EN_BIT]),
    .ctl_clr  (mem_data[CTL_CLR_BIT]),
    .lo_rd    (tmr_lo_rd),
    .count_lo (tmr_count_lo),
    .enable   (tmr_enable),
    .shadow   (tmr_shadow)
  );

  always_comb begin
    rd_data = UNMAPPED_DATA;
    if (hit_ram) begin
      rd_data = ram[ram_index];
    end else if (hit_io) begin
      case (io_ofs)
        OFS_GPIO_OUT: rd_data = gpio_out;
        OFS_GPIO_IN:  rd_data = gpio_sync2;
        OFS_TMR_LO:   rd_data = tmr_count_lo;
        OFS_TMR_HI:   rd_data = tmr_shadow;
        OFS_TMR_CTL: begin
          rd_data = UNMAPPED_DATA;
          rd_data[CTL_EN_BIT] = tmr_enable;
        end
        default:      rd_data = UNMAPPED_DATA;
      endcase
    end
  end

  // The loader owns the RAM write port in LOAD; the CPU owns it in RUN.
  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = load_ptr;
    ram_wdata = load_data;
    if (state == ST_LOAD) begin
      ram_we = load_valid;
    end else if (mem_rw && hit_ram) begin
      ram_we    = 1'b1;
      ram_waddr = ram_index;
      ram_wdata = mem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (!rst && ram_we) begin
      ram[ram_waddr] <= ram_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= LOAD_EN ? ST_LOAD : ST_RUN;
      load_ptr   <= '0;
      mem_q      <= '0;
      gpio_out   <= '0;
      gpio_sync1 <= '0;
      gpio_sync2 <= '0;
      cpu_rst    <= LOAD_EN;
      load_ready <= LOAD_EN;
      load_done  <= !LOAD_EN;
    end else begin
      gpio_sync1 <= gpio_in;
      gpio_sync2 <= gpio_sync1;
      if (state == ST_LOAD) begin
        if (load_valid) begin
          load_ptr <= load_ptr + ADDR_WIDTH'(1);
          // Filling the last RAM byte ends the load even without load_last.
          if (load_last || (load_ptr == LAST_PTR)) begin
            state      <= ST_RUN;
            cpu_rst    <= 1'b0;
            load_ready <= 1'b0;
            load_done  <= 1'b1;
          end
        end
      end else begin
        if (mem_rw) begin
          if (hit_io && (io_ofs == OFS_GPIO_OUT)) begin
            gpio_out <= mem_data;
          end
        end else begin
          mem_q <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed load/timer/reset steps plus a
// randomized RAM/GPIO/unmapped traffic phase checked against an address-map model.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_rw;
  logic [15:0] mem_addr;
  logic [7:0]  mem_data;
  logic [7:0]  mem_q;
  logic        cpu_rst;
  logic        load_valid;
  logic [7:0]  load_data;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;
  int en_edge  = 0;
  int r_edge;
  int sel;

  logic [7:0]  ram_model [256];
  bit          ram_known [256];
  logic [7:0]  gpio_model;
  logic [7:0]  q_model;
  logic [7:0]  img [256];
  logic [15:0] t_exp;
  logic [15:0] r_addr;
  logic        r_w;
  logic [7:0]  r_data;
  logic [7:0]  g_val;

  mem_responder #(
    .ADDR_WIDTH (8),
    .MMIO_BASE  (16'hFF00),
    .LOAD_EN    (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_q      (mem_q),
    .cpu_rst    (cpu_rst),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .load_done  (load_done),
    .gpio_in    (gpio_in),
    .gpio_out   (gpio_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cpu_op(input logic rw, input logic [15:0] addr, input logic [7:0] data);
    mem_rw   = rw;
    mem_addr = addr;
    mem_data = data;
    @(posedge clk);
    #1;
  endtask

  // Idle cycles issue dropped writes to an unmapped address so mem_q is undisturbed.
  task automatic idle_cycles(input int n);
    mem_rw   = 1'b1;
    mem_addr = 16'h0100;
    mem_data = 8'h00;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  function automatic logic [15:0] tmr_at(input int edge_idx);
    return 16'(edge_idx - en_edge - 1);
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    if (a < 16'h0100) return ram_model[a[7:0]];
    if (a == 16'hFF00) return gpio_model;
    return 8'h00;
  endfunction

  initial begin
    rst = 1'b1; mem_rw = 1'b1; mem_addr = 16'h0100; mem_data = 8'h00;
    load_valid = 1'b0; load_data = 8'h00; load_last = 1'b0; gpio_in = 8'h00;
    gpio_model = 8'h00; q_model = 8'h00;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check_output("rst_cpu_rst", cpu_rst, 1'b1);
    check_output("rst_load_ready", load_ready, 1'b1);
    check_output("rst_load_done", load_done, 1'b0);
    check_output("rst_mem_q", mem_q, 8'h00);
    check_output("rst_gpio_out", gpio_out, 8'h00);

    // Boot load of a three-byte image while the CPU port is exercised and ignored.
    mem_rw = 1'b1; mem_addr = 16'hFF00; mem_data = 8'h77;
    load_byte(8'h11, 1'b0);
    check_output("load_ignores_cpu_wr", gpio_out, 8'h00);
    mem_rw = 1'b0; mem_addr = 16'h0000;
    load_byte(8'h22, 1'b0);
    check_output("load_ignores_cpu_rd", mem_q, 8'h00);
    check_output("load_cpu_rst_held", cpu_rst, 1'b1);
    mem_rw = 1'b1; mem_addr = 16'h0100;
    load_byte(8'h33, 1'b1);
    check_output("load_end_cpu_rst", cpu_rst, 1'b0);
    check_output("load_end_done", load_done, 1'b1);
    check_output("load_end_ready", load_ready, 1'b0);
    ram_model[0] = 8'h11; ram_model[1] = 8'h22; ram_model[2] = 8'h33;
    ram_known[0] = 1'b1; ram_known[1] = 1'b1; ram_known[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cpu_op(1'b0, 16'(i), 8'h00);
      check_output("load_ram_readback", mem_q, ram_model[i]);
    end
    q_model = 8'h33;

    // RAM, boundary and unmapped accesses.
    cpu_op(1'b1, 16'h0010, 8'hA5);
    check_output("wr_holds_mem_q", mem_q, q_model);
    cpu_op(1'b0, 16'h0010, 8'h00);
    check_output("ram_rd_after_wr", mem_q, 8'hA5);
    ram_model[16] = 8'hA5; ram_known[16] = 1'b1;
    cpu_op(1'b1, 16'h00FF, 8'hC3);
    cpu_op(1'b0, 16'h00FF, 8'h00);
    check_output("ram_top_byte", mem_q, 8'hC3);
    ram_model[255] = 8'hC3; ram_known[255] = 1'b1;
    cpu_op(1'b1, 16'h0100, 8'h5C);
    cpu_op(1'b0, 16'h0100, 8'h00);
    check_output("unmapped_0100", mem_q, 8'h00);
    cpu_op(1'b0, 16'h0000, 8'h00);
    check_output("no_alias_0000", mem_q, 8'h11);
    cpu_op(1'b0, 16'hFF05, 8'h00);
    check_output("unmapped_io_ofs", mem_q, 8'h00);

    // GPIO output register and synchronised input.
    cpu_op(1'b1, 16'hFF00, 8'h5A);
    check_output("gpio_out_wr", gpio_out, 8'h5A);
    gpio_model = 8'h5A;
    cpu_op(1'b0, 16'hFF00, 8'h00);
    check_output("gpio_out_rd", mem_q, 8'h5A);
    g_val = 8'($urandom);
    gpio_in = g_val;
    idle_cycles(2);
    cpu_op(1'b0, 16'hFF01, 8'h00);
    check_output("gpio_in_sync", mem_q, g_val);
    q_model = g_val;

    // Randomized traffic over RAM, GPIO_OUT and unmapped space.
    for (int i = 0; i < 150; i++) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0, 1:    r_addr = {8'h00, 8'($urandom)};
        2:       r_addr = 16'h0100 + 16'($urandom_range(0, 32'hFDFF));
        default: r_addr = ($urandom_range(0, 1) == 0) ? 16'hFF00 : {8'hFF, 8'($urandom_range(5, 255))};
      endcase
      r_w    = 1'($urandom_range(0, 1));
      r_data = 8'($urandom);
      if (!r_w && (r_addr < 16'h0100) && !ram_known[r_addr[7:0]]) r_w = 1'b1;
      cpu_op(r_w, r_addr, r_data);
      if (r_w) begin
        if (r_addr < 16'h0100) begin
          ram_model[r_addr[7:0]] = r_data;
          ram_known[r_addr[7:0]] = 1'b1;
        end else if (r_addr == 16'hFF00) begin
          gpio_model = r_data;
        end
      end else begin
        q_model = model_read(r_addr);
      end
      check_output("rand_mem_q", mem_q, q_model);
      check_output("rand_gpio_out", gpio_out, gpio_model);
    end

    // Timer: enable, coherent 16-bit reads via the shadow.
    cpu_op(1'b1, 16'hFF04, 8'h01);
    en_edge = cyc;
    idle_cycles(300);
    cpu_op(1'b0, 16'hFF02, 8'h00);
    t_exp = tmr_at(cyc);
    check_output("tmr_lo_300", mem_q, t_exp[7:0]);
    cpu_op(1'b0, 16'hFF03, 8'h00);
    check_output("tmr_hi_300", mem_q, t_exp[15:8]);
    r_edge = en_edge + 16'h0200;
    idle_cycles(r_edge - 1 - cyc);
    cpu_op(1'b0, 16'hFF02, 8'h00);
    t_exp = tmr_at(cyc);
    check_output("tmr_lo_01ff", mem_q, 8'hFF);
    cpu_op(1'b0, 16'hFF03, 8'h00);
    check_output("tmr_hi_shadow", mem_q, t_exp[15:8]);

    // Timer wrap from 0xFFFF to 0x0000.
    r_edge = en_edge + 32'h10000;
    idle_cycles(r_edge - 1 - cyc);
    cpu_op(1'b0, 16'hFF02, 8'h00);
    check_output("tmr_lo_ffff", mem_q, 8'hFF);
    cpu_op(1'b0, 16'hFF03, 8'h00);
    check_output("tmr_hi_ffff", mem_q, 8'hFF);
    cpu_op(1'b0, 16'hFF02, 8'h00);
    t_exp = tmr_at(cyc);
    check_output("tmr_lo_wrap", mem_q, t_exp[7:0]);
    cpu_op(1'b0, 16'hFF03, 8'h00);
    check_output("tmr_hi_wrap", mem_q, t_exp[15:8]);

    // Clear with enable kept set.
    idle_cycles(5);
    cpu_op(1'b1, 16'hFF04, 8'h03);
    en_edge = cyc;
    q_model = t_exp[15:8];
    check_output("tmr_clr_holds_q", mem_q, q_model);
    cpu_op(1'b0, 16'hFF02, 8'h00);
    check_output("tmr_clr_lo", mem_q, 8'h00);
    cpu_op(1'b0, 16'hFF03, 8'h00);
    check_output("tmr_clr_hi", mem_q, 8'h00);
    cpu_op(1'b0, 16'hFF04, 8'h00);
    check_output("tmr_ctl_en_kept", mem_q, 8'h01);
    cpu_op(1'b0, 16'hFF02, 8'h00);
    t_exp = tmr_at(cyc);
    check_output("tmr_runs_after_clr", mem_q, t_exp[7:0]);

    // Reset mid-run, then reset again mid-load after two bytes.
    rst = 1'b1;
    #2;
    check_output("runrst_cpu_rst", cpu_rst, 1'b1);
    check_output("runrst_mem_q", mem_q, 8'h00);
    check_output("runrst_gpio_out", gpio_out, 8'h00);
    check_output("runrst_load_done", load_done, 1'b0);
    @(negedge clk) rst = 1'b0;
    idle_cycles(1);
    for (int i = 0; i < 256; i++) img[i] = 8'($urandom);
    load_byte(~img[0], 1'b0);
    load_byte(~img[1], 1'b0);
    rst = 1'b1;
    #2;
    check_output("loadrst_cpu_rst", cpu_rst, 1'b1);
    check_output("loadrst_load_ready", load_ready, 1'b1);
    check_output("loadrst_mem_q", mem_q, 8'h00);
    @(negedge clk) rst = 1'b0;

    // Full-depth reload without load_last ends at the last RAM byte.
    for (int i = 0; i < 256; i++) begin
      load_byte(img[i], 1'b0);
      if (i == 254) begin
        check_output("full_load_ready_254", load_ready, 1'b1);
        check_output("full_load_cpu_rst_254", cpu_rst, 1'b1);
      end
    end
    check_output("full_load_cpu_rst", cpu_rst, 1'b0);
    check_output("full_load_done", load_done, 1'b1);
    check_output("full_load_ready", load_ready, 1'b0);
    load_valid = 1'b1;
    load_data  = 8'hEE;
    cpu_op(1'b0, 16'h0000, 8'h00);
    load_valid = 1'b0;
    check_output("reload_ram_0", mem_q, img[0]);
    cpu_op(1'b0, 16'h0001, 8'h00);
    check_output("reload_ram_1", mem_q, img[1]);
    cpu_op(1'b0, 16'h00FF, 8'h00);
    check_output("reload_ram_ff", mem_q, img[255]);
    for (int i = 0; i < 8; i++) begin
      r_addr = {8'h00, 8'($urandom)};
      cpu_op(1'b0, r_addr, 8'h00);
      check_output("reload_ram_rand", mem_q, img[r_addr[7:0]]);
    end
    cpu_op(1'b0, 16'hFF04, 8'h00);
    check_output("reload_tmr_ctl", mem_q, 8'h00);
    cpu_op(1'b0, 16'hFF02, 8'h00);
    check_output("reload_tmr_lo", mem_q, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
